// File: rtl/xrs_wb.sv
// xrs writeback sequencer: ALU/LSU arbitration onto the register-file write port plus
// pending-destination scoreboard. Optional operand forwarding when XRS_WB_FWD_EN is defined.
module xrs_wb #(
    parameter int XLEN   = 64,
    parameter int STARVE = 3
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            iss_i,
    input  logic [4:0]      iss_rd_i,
    output logic [31:0]     busy_o,
    input  logic            alu_valid_i,
    input  logic [4:0]      alu_rd_i,
    input  logic [XLEN-1:0] alu_dat_i,
    output logic            alu_ack_o,
    input  logic            lsu_valid_i,
    input  logic [4:0]      lsu_rd_i,
    input  logic [XLEN-1:0] lsu_dat_i,
    output logic            lsu_ack_o,
`ifdef XRS_WB_FWD_EN
    input  logic [4:0]      ra_i,
    input  logic [4:0]      rb_i,
    output logic            fwda_o,
    output logic            fwdb_o,
`endif
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] rdat_o,
    output logic            rwe_o,
    output logic            err_o
);
    localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);

    logic [SW-1:0]   starve_q, starve_d;
    logic [31:0]     busy_q, busy_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] rdat_q, rdat_d;
    logic            rwe_q, rwe_d;
    logic            err_q, err_d;

    logic            alu_pri;
    logic            gnt_alu, gnt_lsu, xfer;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_dat;
    logic [31:0]     clr_mask, set_mask;

    assign alu_pri = (starve_q == SW'(STARVE));

    always_comb begin
        gnt_alu = 1'b0;
        gnt_lsu = 1'b0;
        if (!reset_i) begin
            gnt_alu = alu_valid_i & (~lsu_valid_i | alu_pri);
            gnt_lsu = lsu_valid_i & ~gnt_alu;
        end
    end

    assign xfer  = gnt_alu | gnt_lsu;
    assign w_rd  = gnt_alu ? alu_rd_i : lsu_rd_i;
    assign w_dat = gnt_alu ? alu_dat_i : lsu_dat_i;

    always_comb begin
        starve_d = '0;
        if (alu_valid_i && !gnt_alu && !reset_i) begin
            starve_d = alu_pri ? starve_q : starve_q + SW'(1);
        end
    end

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (xfer && w_rd != 5'd0) clr_mask[w_rd] = 1'b1;
        if (iss_i && iss_rd_i != 5'd0) set_mask[iss_rd_i] = 1'b1;
    end

    // set after clear so a new producer wins over a retiring one
    always_comb begin
        busy_d = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
        err_d = err_q;
        if (|(clr_mask & ~busy_q)) err_d = 1'b1;
        if (|(set_mask & busy_q & ~clr_mask)) err_d = 1'b1;
    end

    always_comb begin
        rd_d   = rd_q;
        rdat_d = rdat_q;
        rwe_d  = 1'b0;
        if (xfer) begin
            rd_d   = w_rd;
            rdat_d = w_dat;
            rwe_d  = (w_rd != 5'd0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_q <= '0;
            busy_q   <= '0;
            rd_q     <= '0;
            rdat_q   <= '0;
            rwe_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            starve_q <= starve_d;
            busy_q   <= busy_d;
            rd_q     <= rd_d;
            rdat_q   <= rdat_d;
            rwe_q    <= rwe_d;
            err_q    <= err_d;
        end
    end

    assign alu_ack_o = gnt_alu;
    assign lsu_ack_o = gnt_lsu;
    assign busy_o    = busy_q;
    assign rd_o      = rd_q;
    assign rdat_o    = rdat_q;
    assign rwe_o     = rwe_q;
    assign err_o     = err_q;

`ifdef XRS_WB_FWD_EN
    assign fwda_o = rwe_q & (rd_q == ra_i) & (ra_i != 5'd0);
    assign fwdb_o = rwe_q & (rd_q == rb_i) & (rb_i != 5'd0);
`endif

endmodule
